ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_if.sv | 34 +++
 rtl/ps2_key_decoder.sv | 146 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// PS/2 FIFO handshake plus decoded key-event outputs of ps2_key_decoder.
// master = FIFO/host side, slave = decoder side.
interface ps2_key_decoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic [7:0]       data;
  logic             ready;
  logic             overflow;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_break;
  logic             key_repeat;
  logic [7:0]       ascii;
  logic             shift;
  logic             caps;
  logic             key_down;
  logic [CNT_W-1:0] press_cnt;
  logic             err;
  logic             ovf_seen;

  modport master (
    output data, ready, overflow,
    input  nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
    input  ascii, shift, caps, key_down, press_cnt, err, ovf_seen
  );

  modport slave (
    input  data, ready, overflow,
    output nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
    output ascii, shift, caps, key_down, press_cnt, err, ovf_seen
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Pops PS/2 set-2 bytes from a FIFO and turns them into key events with
// make/break/repeat flags, modifier state, ASCII and a press counter.
module ps2_key_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  ps2_key_decoder_if.slave bus
);

  typedef enum logic [1:0] {StWait, StDec, StGap} state_e;

  state_e           state_q;
  logic [7:0]       byte_q;
  logic             ext_q, brk_q;
  logic [8:0]       held_q;
  logic             nextdata_n_q, key_valid_q, err_q, ovf_seen_q;
  logic [7:0]       key_code_q, ascii_q;
  logic             key_ext_q, key_break_q, key_repeat_q;
  logic             shift_q, caps_q;
  logic [CNT_W-1:0] press_cnt_q;

  logic [8:0] code9;
  logic       is_mod, is_caps, is_repeat;
  logic [7:0] ascii_lc, ascii_d;

  function automatic logic [7:0] set2_lower(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6a; 8'h42: return 8'h6b; 8'h4B: return 8'h6c;
      8'h3A: return 8'h6d; 8'h31: return 8'h6e; 8'h44: return 8'h6f; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7a;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    code9     = {ext_q, byte_q};
    is_mod    = !ext_q && (byte_q == 8'h12 || byte_q == 8'h59);
    is_caps   = !ext_q && (byte_q == 8'h58);
    // held never contains 0, and 00h never reaches the event path
    is_repeat = !brk_q && (code9 == held_q);
    ascii_lc  = set2_lower(byte_q);
    ascii_d   = 8'h00;
    if (!ext_q && !brk_q) begin
      ascii_d = ascii_lc;
      if ((shift_q ^ caps_q) && ascii_lc >= 8'h61 && ascii_lc <= 8'h7a) begin
        ascii_d = ascii_lc - 8'h20;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWait;
      byte_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= '0;
      nextdata_n_q <= 1'b1;
      key_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      ovf_seen_q   <= 1'b0;
      key_code_q   <= '0;
      ascii_q      <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      shift_q      <= 1'b0;
      caps_q       <= 1'b0;
      press_cnt_q  <= '0;
    end else begin
      if (bus.overflow) ovf_seen_q <= 1'b1;
      key_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      unique case (state_q)
        StWait: begin
          if (bus.ready) begin
            byte_q       <= bus.data;
            nextdata_n_q <= 1'b0;
            state_q      <= StDec;
          end
        end
        StDec: begin
          state_q <= StGap;
          if (byte_q == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (byte_q == 8'hF0) begin
            brk_q <= 1'b1;
          end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            err_q <= 1'b1;
          end else begin
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            key_valid_q  <= 1'b1;
            key_code_q   <= byte_q;
            key_ext_q    <= ext_q;
            key_break_q  <= brk_q;
            key_repeat_q <= is_repeat;
            ascii_q      <= ascii_d;
            if (is_mod) begin
              shift_q <= !brk_q;
            end else if (!brk_q) begin
              if (!is_repeat) begin
                press_cnt_q <= press_cnt_q + CNT_W'(1);
                // caps lock toggles but is never tracked as the held key
                if (is_caps) caps_q <= !caps_q;
                else         held_q <= code9;
              end
            end else if (code9 == held_q) begin
              held_q <= '0;
            end
          end
        end
        StGap:   state_q <= StWait;
        default: state_q <= StWait;
      endcase
    end
  end

  assign bus.nextdata_n = nextdata_n_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;
  assign bus.key_ext    = key_ext_q;
  assign bus.key_break  = key_break_q;
  assign bus.key_repeat = key_repeat_q;
  assign bus.ascii      = ascii_q;
  assign bus.shift      = shift_q;
  assign bus.caps       = caps_q;
  assign bus.key_down   = (held_q != '0);
  assign bus.press_cnt  = press_cnt_q;
  assign bus.err        = err_q;
  assign bus.ovf_seen   = ovf_seen_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and random byte streams into two decoders (CNT_W=8 and CNT_W=2),
// checked against a key-event model built from the decoding rules.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  ps2_key_decoder_if #(.CNT_W(8)) bus8 ();
  ps2_key_decoder_if #(.CNT_W(2)) bus2 ();

  assign bus8.data = data;
  assign bus8.ready = ready;
  assign bus8.overflow = overflow;
  assign bus2.data = data;
  assign bus2.ready = ready;
  assign bus2.overflow = overflow;

  ps2_key_decoder #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  ps2_key_decoder #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};

  // Model state: pending prefixes, currently held key id (0 = none), modifiers, last event.
  bit         m_ext, m_brk, m_shift, m_caps, m_ovf;
  int         m_held, m_cnt;
  logic [7:0] m_code, m_ascii;
  bit         m_kext, m_kbrk, m_krep;

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit upper);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return upper ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return 8'(48 + i);
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_shift = 0; m_caps = 0; m_ovf = 0;
    m_held = 0; m_cnt = 0; m_code = 0; m_ascii = 0; m_kext = 0; m_kbrk = 0; m_krep = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ev, output bit er);
    int id;
    bit modk, capsk, rep;
    ev = 0; er = 0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 0; m_brk = 0; er = 1;
    end else begin
      id    = m_ext ? 256 + int'(b) : int'(b);
      modk  = !m_ext && (b == 8'h12 || b == 8'h59);
      capsk = !m_ext && (b == 8'h58);
      rep   = !m_brk && (id == m_held);
      m_code = b; m_kext = m_ext; m_kbrk = m_brk; m_krep = rep;
      m_ascii = (m_ext || m_brk) ? 8'h00 : ref_ascii(b, m_shift ^ m_caps);
      if (modk) m_shift = !m_brk;
      else if (!m_brk) begin
        if (!rep) begin
          m_cnt++;
          if (capsk) m_caps = !m_caps;
          else m_held = id;
        end
      end else if (id == m_held) m_held = 0;
      m_ext = 0; m_brk = 0; ev = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("key_code", 32'(bus8.key_code), 32'(m_code));
    check("key_ext", 32'(bus8.key_ext), 32'(m_kext));
    check("key_break", 32'(bus8.key_break), 32'(m_kbrk));
    check("key_repeat", 32'(bus8.key_repeat), 32'(m_krep));
    check("ascii", 32'(bus8.ascii), 32'(m_ascii));
    check("shift", 32'(bus8.shift), 32'(m_shift));
    check("caps", 32'(bus8.caps), 32'(m_caps));
    check("key_down", 32'(bus8.key_down), 32'(m_held != 0));
    check("press_cnt8", 32'(bus8.press_cnt), 32'(m_cnt % 256));
    check("press_cnt2", 32'(bus2.press_cnt), 32'(m_cnt % 4));
    check("ovf_seen", 32'(bus8.ovf_seen), 32'(m_ovf));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(bus8.key_valid), 32'd0);
    check({tag, "_err"}, 32'(bus8.err), 32'd0);
    check({tag, "_pop"}, 32'(bus8.nextdata_n), 32'd1);
    check_outputs();
  endtask

  // One byte: capture edge, DEC cycle (pop low), GAP cycle (results), back to WAIT.
  task automatic send(input logic [7:0] b);
    bit ev, er;
    @(negedge clk); data = b; ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    check("pop_low", 32'(bus8.nextdata_n), 32'd0);
    model_byte(b, ev, er);
    @(posedge clk); #1;
    check("key_valid", 32'(bus8.key_valid), 32'(ev));
    check("err", 32'(bus8.err), 32'(er));
    check("pop_high", 32'(bus8.nextdata_n), 32'd1);
    check_outputs();
    @(posedge clk); #1;
    check("valid_pulse", 32'(bus8.key_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_reset_state("rst");
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b, last_b;
    int r;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_state("por");
    @(negedge clk); rst = 1'b0;

    // Make then break of 'q'
    send(8'h15);
    check("q_ascii", 32'(bus8.ascii), 32'h71);
    check("q_cnt", 32'(bus8.press_cnt), 32'd1);
    send(8'hF0); send(8'h15);
    check("q_brk", 32'(bus8.key_break), 32'd1);
    check("q_up", 32'(bus8.key_down), 32'd0);

    // Auto-repeat
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("a_rep", 32'(bus8.key_repeat), 32'd1);
    check("a_cnt", 32'(bus8.press_cnt), 32'd1);

    // Shift, then caps lock
    do_reset();
    send(8'h12); send(8'h23);
    check("D_shift", 32'(bus8.ascii), 32'h44);
    send(8'hF0); send(8'h12); send(8'h58); send(8'h23);
    check("D_caps", 32'(bus8.ascii), 32'h44);
    check("caps_on", 32'(bus8.caps), 32'd1);
    check("sc_cnt", 32'(bus8.press_cnt), 32'd2);

    // Extended make/break and bad byte
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_brk", 32'(bus8.key_ext & bus8.key_break), 32'd1);
    send(8'hE0); send(8'hE0); send(8'hFF);
    send(8'hF0); send(8'hF0); send(8'h00);

    // Counter wrap on the narrow instance
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    check("cnt2_wrap", 32'(bus2.press_cnt), 32'd1);
    check("cnt8_five", 32'(bus8.press_cnt), 32'd5);

    // Throughput with ready stuck high
    do_reset();
    @(negedge clk); data = 8'h29; ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("pop_rate", 32'(bus8.nextdata_n), (i % 3 == 0) ? 32'd0 : 32'd1);
    end

    // Reset landing in the DEC cycle
    do_reset();
    send(8'h1C); send(8'h12);
    @(negedge clk); data = 8'h32; ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_reset_state("rst_dec");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 check("rst_dec_noev", 32'(bus8.key_valid), 32'd0);

    // Sticky overflow
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    m_ovf = 1;
    send(8'h4D);

    // Random traffic
    last_b = 8'h1C;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 15));
      if (r <= 5) b = letter_codes[$urandom_range(0, 25)];
      else if (r == 6) b = digit_codes[$urandom_range(0, 9)];
      else if (r == 7) b = last_b;
      else if (r == 8) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (r == 9) b = 8'h58;
      else if (r == 10) b = 8'hF0;
      else if (r == 11) b = 8'hE0;
      else if (r == 12) b = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
      else if (r == 13) b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
      else b = 8'($urandom);
      if (b != 8'hF0 && b != 8'hE0) last_b = b;
      send(b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
